// File: rtl/store_checker.sv
// In-order checker for data-memory stores against an expected-store table, with a cycle budget.
// Optional STORE_CHECKER_TRACE_EN compiles in simulation-only per-compare and verdict printing.
module store_checker #(
   parameter int WIDTH     = 32,
   parameter int ADDRBITS  = 16,
   parameter int DEPTH     = 8,
   parameter int IDXBITS   = 6,
   parameter int MAXCYCLES = 1000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                memwrite,
   input  logic [ADDRBITS-1:0] addr,
   input  logic [WIDTH-1:0]    wdata,
   input  logic [IDXBITS:0]    num_expected,
   output logic [IDXBITS-1:0]  exp_idx,
   input  logic [ADDRBITS-1:0] exp_addr,
   input  logic [WIDTH-1:0]    exp_data,
   output logic                done,
   output logic                pass,
   output logic                fail,
   output logic                timeout,
   output logic [IDXBITS:0]    err_count,
   output logic [IDXBITS:0]    store_count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = $clog2(MAXCYCLES + 1);
   localparam int EW    = ADDRBITS + WIDTH;
   localparam int CNT_W = IDXBITS + 1;

   typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL} state_t;

   state_t            r_state, w_next;
   logic [EW-1:0]     r_mem [DEPTH];
   logic [AW:0]       r_wp, r_rp;
   logic [CNT_W-1:0]  r_num, r_err, r_cnt;
   logic [CW-1:0]     r_cyc;
   logic              r_tmo, r_ovf;

   logic              w_run, w_empty, w_full, w_pop, w_push_req, w_push, w_ovf;
   logic              w_mis, w_extra, w_done_hit, w_tmo_hit;
   logic [EW-1:0]     w_head;
   logic [CW-1:0]     w_cyc_nxt;

   assign w_run      = (r_state == S_RUN);
   assign w_empty    = (r_wp == r_rp);
   assign w_full     = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_pop      = w_run && !w_empty;
   assign w_push_req = w_run && memwrite;
   // A pop in the same cycle frees a slot, so a full FIFO only overflows without one.
   assign w_ovf      = w_push_req && w_full && !w_pop;
   assign w_push     = w_push_req && !w_ovf;
   assign w_head     = r_mem[r_rp[AW-1:0]];
   assign w_mis      = (w_head != {exp_addr, exp_data});
   assign w_extra    = w_pop && (r_cnt == r_num);
   assign w_done_hit = w_empty && (r_cnt == r_num);
   assign w_cyc_nxt  = r_cyc + CW'(1);
   assign w_tmo_hit  = w_run && (w_cyc_nxt == CW'(MAXCYCLES));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_RUN: begin
            if (w_tmo_hit || w_ovf || r_ovf || w_extra)
               w_next = S_FAIL;
            else if (w_done_hit)
               w_next = (memwrite || (r_err != '0)) ? S_FAIL : S_PASS;
         end
         S_PASS:  if (memwrite) w_next = S_FAIL;
         S_FAIL:  w_next = S_FAIL;
         default: w_next = S_FAIL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp[AW-1:0]] <= {addr, wdata};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_RUN;
         r_wp    <= '0;
         r_rp    <= '0;
         r_err   <= '0;
         r_cnt   <= '0;
         r_cyc   <= '0;
         r_tmo   <= 1'b0;
         r_ovf   <= 1'b0;
         r_num   <= num_expected;
      end else begin
         r_state <= w_next;
         if (w_push) r_wp <= r_wp + (AW+1)'(1);
         if (w_pop) begin
            r_rp <= r_rp + (AW+1)'(1);
            if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
            if (w_mis && (r_err != '1)) r_err <= r_err + CNT_W'(1);
         end
         // Counter only advances in RUN, so it freezes once a verdict is reached.
         if (w_run) r_cyc <= w_cyc_nxt;
         if (w_tmo_hit) r_tmo <= 1'b1;
         if (w_ovf) r_ovf <= 1'b1;
      end
   end

   assign exp_idx     = r_cnt[IDXBITS-1:0];
   assign done        = (r_state != S_RUN);
   assign pass        = (r_state == S_PASS);
   assign fail        = (r_state == S_FAIL);
   assign timeout     = r_tmo;
   assign err_count   = r_err;
   assign store_count = r_cnt;

`ifdef STORE_CHECKER_TRACE_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_pop)
            $display("store_checker: idx %0d addr %h data %h %s", exp_idx,
                     w_head[EW-1:WIDTH], w_head[WIDTH-1:0], w_mis ? "MISMATCH" : "MATCH");
         if ((w_next != r_state) && (w_next != S_RUN))
            $display("store_checker: verdict %s stores %0d errors %0d timeout %0b",
                     (w_next == S_PASS) ? "PASS" : "FAIL", r_cnt, r_err, w_tmo_hit || r_tmo);
      end
   end
`else
`endif

endmodule
